// File: rtl/usb_crc_pkg.sv
// ----------------------------------------------------------------------------
// usb_crc_pkg
//   Definitions shared by the USB CRC16 transmit generator and receive checker.
//   It holds the transmit FSM state encoding and the CRC16 constants: the
//   polynomial, the seed, and the residual that a good packet leaves behind.
// ----------------------------------------------------------------------------
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } crc_tx_state_t;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/crc16_lfsr_step.sv
// ----------------------------------------------------------------------------
// crc16_lfsr_step
//   Combinational single-bit step of the serial CRC LFSR (MSB-out form). The
//   generator and the checker both use this block, so the two ends of the
//   link share one polynomial implementation.
// Ports
//   crc_in   [CRC_W-1:0]  current CRC register
//   bit_in                serial bit being accepted
//   crc_next [CRC_W-1:0]  CRC register after accepting bit_in
// ----------------------------------------------------------------------------
module crc16_lfsr_step
    import usb_crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC16_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_next
);

    logic fb;

    // The x^CRC_W term is implicit: it is the bit that shifts out of the MSB.
    assign fb       = bit_in ^ crc_in[CRC_W-1];
    assign crc_next = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_16_generator.sv
// ----------------------------------------------------------------------------
// crc_16_generator
//   USB transmit-side CRC16 unit that sits ahead of bit-stuffing/NRZI. It
//   echoes the serial payload one clock after each shift_en strobe while it
//   folds every bit into the CRC. After the last payload bit it appends the
//   16 inverted CRC bits, MSB first.
// Ports
//   clk        system clock (rising edge)
//   n_rst      synchronous reset, active low
//   start      begin a packet (sampled only in IDLE)
//   no_data    with start: zero-length payload, go straight to the CRC phase
//   abort      drop the current packet and return to IDLE
//   shift_en   one-cycle bit strobe at the USB bit rate
//   data_in    payload bit, LSB of each byte first
//   data_last  marks the final payload bit
//   data_out   registered serial output bit
//   out_valid  pulse: data_out was updated this cycle
//   crc_phase  data_out holds a CRC bit
//   busy       in the DATA or CRC state
//   done       pulse with the out_valid of the 16th CRC bit
// ----------------------------------------------------------------------------
module crc_16_generator
    import usb_crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
    parameter logic [CRC_W-1:0] INIT  = CRC16_INIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start,
    input  logic no_data,
    input  logic abort,
    input  logic shift_en,
    input  logic data_in,
    input  logic data_last,
    output logic data_out,
    output logic out_valid,
    output logic crc_phase,
    output logic busy,
    output logic done
);

    localparam int               CNT_W    = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

    crc_tx_state_t    state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             crc_phase_q, crc_phase_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CRC_W-1:0] crc_step;

    crc16_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr_step (
        .crc_in   (crc_q),
        .bit_in   (data_in),
        .crc_next (crc_step)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        crc_phase_d = crc_phase_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            crc_d       = INIT;
            bit_cnt_d   = '0;
            busy_d      = 1'b0;
            crc_phase_d = 1'b0;
        end else if (!abort) begin
            unique case (state_q)
                IDLE: begin
                    // A strobe arriving together with start is discarded.
                    if (start) begin
                        state_d     = no_data ? CRC : DATA;
                        crc_d       = INIT;
                        bit_cnt_d   = '0;
                        busy_d      = 1'b1;
                        crc_phase_d = 1'b0;
                    end
                end
                DATA: begin
                    if (shift_en) begin
                        data_out_d  = data_in;
                        out_valid_d = 1'b1;
                        crc_phase_d = 1'b0;
                        crc_d       = crc_step;
                        if (data_last) begin
                            state_d   = CRC;
                            bit_cnt_d = '0;
                        end
                    end
                end
                CRC: begin
                    // Shifting in ones restores the register to INIT
                    // after the 16 inverted bits have gone out.
                    if (shift_en) begin
                        data_out_d  = ~crc_q[CRC_W-1];
                        crc_d       = {crc_q[CRC_W-2:0], 1'b1};
                        crc_phase_d = 1'b1;
                        out_valid_d = 1'b1;
                        if (bit_cnt_q == CNT_LAST) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            bit_cnt_q   <= '0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            crc_phase_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            bit_cnt_q   <= bit_cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            crc_phase_q <= crc_phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign crc_phase = crc_phase_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
